// File: rtl/mem_port_arbiter_pkg.sv
// Shared codes for the memory-port arbiter: FSM states, access sizes, port owners
// and the latched request record.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef struct packed {
        owner_t      owner;
        logic        we;
        size_t       size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [3:0] lane_mask(input size_t sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_fmt.sv
// Byte-lane steering for stores, extract/extend for loads, misalignment detect.
// Purely combinational; no state, no backpressure.
module mem_lane_fmt
    import mem_port_arbiter_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  offs,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wlanes,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    assign misalign = (size == SZ_X) ||
                      (size == SZ_H && offs[0]) ||
                      (size == SZ_W && offs != 2'd0);

    assign wmask  = lane_mask(size) << offs;
    assign wlanes = wdata << {offs, 3'b000};

    // RAM has already shifted the addressed byte down to lane 0
    always_comb begin
        rdata_ext = rdata;
        case (size)
            SZ_B:    rdata_ext = {{24{~uns & rdata[7]}}, rdata[7:0]};
            SZ_H:    rdata_ext = {{16{~uns & rdata[15]}}, rdata[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one byte-lane RAM with a starvation guard.
// Latency gnt->rvalid is WAIT_STATES+2; requesters hold until gnt, responses never stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int MAX_STARVE  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic [3:0]  m_wr,
    output logic [31:0] m_addr,
    output logic [7:0]  m_wdata0,
    output logic [7:0]  m_wdata1,
    output logic [7:0]  m_wdata2,
    output logic [7:0]  m_wdata3,
    input  logic [31:0] m_rdata
);

    state_t      state;
    req_t        cur;
    req_t        nxt;
    logic [3:0]  wcnt;
    logic [3:0]  starve;

    logic        arb_ok;
    logic        if_win;
    logic        final_cyc;
    logic        bad;
    logic        fmt_misalign;
    logic [3:0]  fmt_wmask;
    logic [31:0] fmt_wlanes;
    logic [31:0] fmt_rdata;
    logic [31:0] lanes;

    assign final_cyc = (state == ST_ACCESS) && (wcnt == 4'd0);
    assign arb_ok    = (state == ST_IDLE) || final_cyc;
    assign if_win    = if_req && (!d_req || starve == 4'(MAX_STARVE));
    assign if_gnt    = arb_ok && if_win;
    assign d_gnt     = arb_ok && d_req && !if_win;

    always_comb begin
        if (if_gnt) begin
            nxt = '{owner: OWN_IF, we: 1'b0, size: SZ_W, uns: 1'b0,
                    addr: if_addr, wdata: 32'd0};
        end else begin
            nxt = '{owner: OWN_D, we: d_we, size: size_t'(d_size), uns: d_unsigned,
                    addr: d_addr, wdata: d_wdata};
        end
    end

    mem_lane_fmt u_fmt (
        .size      (cur.size),
        .offs      (cur.addr[1:0]),
        .uns       (cur.uns),
        .wdata     (cur.wdata),
        .rdata     (m_rdata),
        .wmask     (fmt_wmask),
        .wlanes    (fmt_wlanes),
        .rdata_ext (fmt_rdata),
        .misalign  (fmt_misalign)
    );

    // Fetches of a misaligned word return the raw shifted data, never an error
    assign bad = fmt_misalign && (cur.owner == OWN_D);

    assign m_en   = (state == ST_ACCESS) && !bad;
    assign m_addr = (state == ST_ACCESS) ? cur.addr : 32'd0;
    assign m_wr   = (final_cyc && cur.we && !bad) ? fmt_wmask : 4'b0000;
    assign lanes  = (state == ST_ACCESS && cur.we && !bad) ? fmt_wlanes : 32'd0;

    assign m_wdata0 = lanes[7:0];
    assign m_wdata1 = lanes[15:8];
    assign m_wdata2 = lanes[23:16];
    assign m_wdata3 = lanes[31:24];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cur       <= '0;
            wcnt      <= 4'd0;
            starve    <= 4'd0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'd0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;

            if (final_cyc) begin
                if (cur.owner == OWN_IF) begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= m_rdata;
                end else begin
                    d_rvalid <= !bad;
                    d_err    <= bad;
                    d_rdata  <= (bad || cur.we) ? 32'd0 : fmt_rdata;
                end
            end

            if (if_gnt || d_gnt) begin
                state <= ST_ACCESS;
                cur   <= nxt;
                wcnt  <= 4'(WAIT_STATES);
                if (if_gnt)
                    starve <= 4'd0;
                else if (if_req)
                    starve <= starve + 4'd1;
            end else if (final_cyc) begin
                state <= ST_IDLE;
            end else if (state == ST_ACCESS) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (WAIT_STATES 0 and 3) each on a byte RAM; vector table,
// latency/starvation/reset sequences, and random traffic against a byte-level model.
module tb_mem_port_arbiter;

    logic clk;
    logic rstn;
    logic ram_clr;

    logic [1:0]            if_req;
    logic [1:0][31:0]      if_addr;
    logic [1:0]            if_gnt;
    logic [1:0]            if_rvalid;
    logic [1:0][31:0]      if_rdata;
    logic [1:0]            d_req;
    logic [1:0]            d_we;
    logic [1:0][1:0]       d_size;
    logic [1:0]            d_unsigned;
    logic [1:0][31:0]      d_addr;
    logic [1:0][31:0]      d_wdata;
    logic [1:0]            d_gnt;
    logic [1:0]            d_rvalid;
    logic [1:0]            d_err;
    logic [1:0][31:0]      d_rdata;
    logic [1:0]            m_en;
    logic [1:0][3:0]       m_wr;
    logic [1:0][31:0]      m_addr;
    logic [1:0][3:0][7:0]  m_wdata;
    logic [1:0][31:0]      m_rdata;

    logic [7:0] ram     [2][256];
    logic [7:0] ref_mem [2][256];

    int tests = 0;
    int fails = 0;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.WAIT_STATES(g == 0 ? 0 : 3), .MAX_STARVE(4)) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .if_req     (if_req[g]),
            .if_addr    (if_addr[g]),
            .if_gnt     (if_gnt[g]),
            .if_rvalid  (if_rvalid[g]),
            .if_rdata   (if_rdata[g]),
            .d_req      (d_req[g]),
            .d_we       (d_we[g]),
            .d_size     (d_size[g]),
            .d_unsigned (d_unsigned[g]),
            .d_addr     (d_addr[g]),
            .d_wdata    (d_wdata[g]),
            .d_gnt      (d_gnt[g]),
            .d_rvalid   (d_rvalid[g]),
            .d_err      (d_err[g]),
            .d_rdata    (d_rdata[g]),
            .m_en       (m_en[g]),
            .m_wr       (m_wr[g]),
            .m_addr     (m_addr[g]),
            .m_wdata0   (m_wdata[g][0]),
            .m_wdata1   (m_wdata[g][1]),
            .m_wdata2   (m_wdata[g][2]),
            .m_wdata3   (m_wdata[g][3]),
            .m_rdata    (m_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: byte array, read data shifted right by the byte offset
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_clr) begin
                for (int i = 0; i < 256; i++) ram[k][i] <= 8'(i) ^ 8'h3C;
            end else if (m_en[k]) begin
                for (int b = 0; b < 4; b++)
                    if (m_wr[k][b]) ram[k][{m_addr[k][7:2], 2'(b)}] <= m_wdata[k][b];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            m_rdata[k] = {ram[k][{m_addr[k][7:2], 2'd3}], ram[k][{m_addr[k][7:2], 2'd2}],
                          ram[k][{m_addr[k][7:2], 2'd1}], ram[k][{m_addr[k][7:2], 2'd0}]}
                         >> {m_addr[k][1:0], 3'b000};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic any_out(input int k);
        return |{if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_err[k],
                 d_rdata[k], m_en[k], m_wr[k], m_addr[k], m_wdata[k]};
    endfunction

    // Reference model: byte-addressed memory updated by the architectural rules
    task automatic model_op(input int k, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] exp_rd, output logic exp_err);
        int nb;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_rd  = 32'd0;
        exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < nb; b++) ref_mem[k][8'(a + b)] = wd[8*b +: 8];
            end else begin
                v = 32'd0;
                for (int b = 0; b < nb; b++) v[8*b +: 8] = ref_mem[k][8'(a + b)];
                if (!uns && nb < 4 && v[8*nb-1])
                    for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
                exp_rd = v;
            end
        end
    endtask

    function automatic logic [31:0] fetch_exp(input int k, input logic [31:0] a);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = ref_mem[k][{a[7:2], 2'(b)}];
        return v >> {a[1:0], 3'b000};
    endfunction

    task automatic d_access(input int k, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic rv, output logic er,
                            output logic [3:0] wr_seen, output logic en_seen,
                            output logic [31:0] lanes);
        int n;
        wr_seen = 4'd0;
        en_seen = 1'b0;
        lanes   = 32'd0;
        @(negedge clk);
        d_we[k] = we; d_size[k] = sz; d_unsigned[k] = uns;
        d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1'b1;
        #1;
        n = 0;
        while (!d_gnt[k] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("d_gnt_wait", 32'(d_gnt[k]), 32'd1);
        @(negedge clk);
        d_req[k] = 1'b0;
        n = 0;
        while (!d_rvalid[k] && !d_err[k] && n < 40) begin
            en_seen |= m_en[k];
            if (m_wr[k] != 4'd0) begin
                wr_seen = m_wr[k];
                lanes   = m_wdata[k];
            end
            @(negedge clk); n++;
        end
        rd = d_rdata[k];
        rv = d_rvalid[k];
        er = d_err[k];
    endtask

    task automatic f_access(input int k, input logic [31:0] a,
                            output logic [31:0] rd, output logic rv);
        int n;
        @(negedge clk);
        if_addr[k] = a; if_req[k] = 1'b1;
        #1;
        n = 0;
        while (!if_gnt[k] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("if_gnt_wait", 32'(if_gnt[k]), 32'd1);
        @(negedge clk);
        if_req[k] = 1'b0;
        n = 0;
        while (!if_rvalid[k] && n < 40) begin
            @(negedge clk); n++;
        end
        rd = if_rdata[k];
        rv = if_rvalid[k];
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_wr;
        logic [31:0] exp_lanes;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, lanes, exp_rd, a, wd;
        logic        rv, er, en_s, exp_err, we, uns, bad_seen;
        logic [3:0]  wr_s;
        logic [1:0]  sz;
        int          k, r, starve_m;
        logic        exp_if;

        // RAM preloaded with byte i = i ^ 0x3C
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h23, 32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5000000};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        32'hFFFFFFA5, 1'b0, 4'b0000, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        32'h000000A5, 1'b0, 4'b0000, 32'h0};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEF0000};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0000, 32'h0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        32'h0000BEEF, 1'b0, 4'b0000, 32'h0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h41, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h12345678, 32'h0,        1'b0, 4'b1111, 32'h12345678};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h12345678, 1'b0, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        32'h00000056, 1'b0, 4'b0000, 32'h0};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,        32'h00001234, 1'b0, 4'b0000, 32'h0};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h06, 32'hDEADBEEF, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h3B3A3938, 1'b0, 4'b0000, 32'h0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h41, 32'h00001111, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[14] = '{1'b0, 2'd1, 1'b1, 32'h40, 32'h0,        32'h00007D7C, 1'b0, 4'b0000, 32'h0};
        tbl[15] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[16] = '{1'b0, 2'd0, 1'b0, 32'h80, 32'h0,        32'hFFFFFFBC, 1'b0, 4'b0000, 32'h0};
        tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h82, 32'h0,        32'hFFFFBFBE, 1'b0, 4'b0000, 32'h0};

        for (int kk = 0; kk < 2; kk++)
            for (int i = 0; i < 256; i++) ref_mem[kk][i] = 8'(i) ^ 8'h3C;

        rstn = 1'b0; ram_clr = 1'b1;
        if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_size = '0;
        d_unsigned = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outs0", 32'(any_out(0)), 32'd0);
        check("reset_outs1", 32'(any_out(1)), 32'd0);
        ram_clr = 1'b0;
        rstn    = 1'b1;
        @(negedge clk);
        check("idle_outs0", 32'(any_out(0)), 32'd0);

        // Vector table on the zero-wait-state instance
        for (int i = 0; i < 18; i++) begin
            model_op(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, exp_rd, exp_err);
            d_access(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                     rd, rv, er, wr_s, en_s, lanes);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_rvalid", i), 32'(rv), 32'(!tbl[i].exp_err));
            check($sformatf("vec%0d_m_wr", i), 32'(wr_s), 32'(tbl[i].exp_wr));
            check($sformatf("vec%0d_m_en", i), 32'(en_s), 32'(!tbl[i].exp_err));
            if (tbl[i].exp_wr != 4'd0)
                check($sformatf("vec%0d_lanes", i), lanes, tbl[i].exp_lanes);
        end

        // Fetch latency: gnt at T, RAM at T+1, rvalid at T+2
        @(negedge clk);
        if_addr[0] = 32'h10; if_req[0] = 1'b1;
        #1;
        check("fetch_gnt_T", 32'(if_gnt[0]), 32'd1);
        check("fetch_dgnt_T", 32'(d_gnt[0]), 32'd0);
        @(negedge clk);
        if_req[0] = 1'b0;
        check("fetch_m_en_T1", 32'(m_en[0]), 32'd1);
        check("fetch_m_addr_T1", m_addr[0], 32'h10);
        check("fetch_rvalid_T1", 32'(if_rvalid[0]), 32'd0);
        @(negedge clk);
        check("fetch_rvalid_T2", 32'(if_rvalid[0]), 32'd1);
        check("fetch_rdata_T2", if_rdata[0], 32'h2F2E2D2C);
        @(negedge clk);
        check("fetch_rvalid_T3", 32'(if_rvalid[0]), 32'd0);

        f_access(0, 32'h12, rd, rv);
        check("fetch_misal_rdata", rd, 32'h00002F2E);
        check("fetch_misal_derr", 32'(d_err[0]), 32'd0);

        // Both ports requesting continuously: starvation guard
        @(negedge clk);
        if_addr[0] = 32'h10; if_req[0] = 1'b1;
        d_we[0] = 1'b0; d_size[0] = 2'd2; d_unsigned[0] = 1'b0; d_addr[0] = 32'h8; d_req[0] = 1'b1;
        starve_m = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_if = (starve_m == 4);
            check($sformatf("starve_two_gnt%0d", c), 32'(if_gnt[0] & d_gnt[0]), 32'd0);
            check($sformatf("starve_if_gnt%0d", c), 32'(if_gnt[0]), 32'(exp_if));
            check($sformatf("starve_d_gnt%0d", c), 32'(d_gnt[0]), 32'(!exp_if));
            starve_m = exp_if ? 0 : starve_m + 1;
            @(negedge clk);
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Three wait states: store occupies RAM for 4 cycles, writes only in the last
        model_op(1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, exp_rd, exp_err);
        @(negedge clk);
        d_we[1] = 1'b1; d_size[1] = 2'd2; d_unsigned[1] = 1'b0;
        d_addr[1] = 32'h8; d_wdata[1] = 32'h12345678; d_req[1] = 1'b1;
        #1;
        check("ws3_gnt_T", 32'(d_gnt[1]), 32'd1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) d_req[1] = 1'b0;
            check($sformatf("ws3_m_en_T%0d", c), 32'(m_en[1]), 32'(c <= 4));
            check($sformatf("ws3_m_wr_T%0d", c), 32'(m_wr[1]), (c == 4) ? 32'hF : 32'h0);
            check($sformatf("ws3_rvalid_T%0d", c), 32'(d_rvalid[1]), 32'(c == 5));
        end
        d_access(1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, rv, er, wr_s, en_s, lanes);
        check("ws3_readback", rd, 32'h12345678);

        // Reset in the middle of a store's ACCESS phase
        @(negedge clk);
        d_we[1] = 1'b1; d_size[1] = 2'd2; d_addr[1] = 32'h30;
        d_wdata[1] = 32'hCAFEF00D; d_req[1] = 1'b1;
        #1;
        check("rst_gnt", 32'(d_gnt[1]), 32'd1);
        @(negedge clk);
        d_req[1] = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_outs_zero", 32'(any_out(1)), 32'd0);
        bad_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) rstn = 1'b1;
            bad_seen |= (m_wr[1] != 4'd0) | d_rvalid[1] | d_err[1];
        end
        check("rst_no_late_resp", 32'(bad_seen), 32'd0);
        check("rst_idle_m_en", 32'(m_en[1]), 32'd0);
        model_op(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, exp_rd, exp_err);
        d_access(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, rv, er, wr_s, en_s, lanes);
        check("rst_ram_unchanged", rd, exp_rd);

        // Random traffic against the byte-level model
        for (int i = 0; i < 160; i++) begin
            k = (i % 5 == 4) ? 1 : 0;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 127));
            if (r < 2) begin
                a[1:0] = 2'd0;
                exp_rd = fetch_exp(k, a);
                f_access(k, a, rd, rv);
                check($sformatf("rnd%0d_fetch_rdata", i), rd, exp_rd);
                check($sformatf("rnd%0d_fetch_rvalid", i), 32'(rv), 32'd1);
            end else begin
                we  = (r < 5);
                sz  = 2'($urandom_range(0, 3));
                uns = 1'($urandom_range(0, 1));
                wd  = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'd0;
                end
                model_op(k, we, sz, uns, a, wd, exp_rd, exp_err);
                d_access(k, we, sz, uns, a, wd, rd, rv, er, wr_s, en_s, lanes);
                check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
                check($sformatf("rnd%0d_err", i), 32'(er), 32'(exp_err));
                check($sformatf("rnd%0d_rvalid", i), 32'(rv), 32'(!exp_err));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
